// File: rtl/quad_step_decoder.sv
// Rotary encoder front end: synchronizes and debounces both channels, then
// turns each debounced A rising edge into a step with direction and a wrapped position.
module quad_step_decoder #(
    parameter int unsigned DEB_CYCLES = 50000,
    parameter int unsigned POS_MOD    = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw,
    input  logic       dt,
    output logic       step,
    output logic       dir,
    output logic [4:0] pos,
    output logic       a_db,
    output logic       b_db
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned POS_W = 5;
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES - 1);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(POS_MOD - 1);

    logic             sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic             dt_s1_q, dt_s1_d, dt_s2_q, dt_s2_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic             a_db_q, a_db_d, b_db_q, b_db_d;
    logic             a_prev_q, a_prev_d, b_prev_q, b_prev_d;
    logic             step_q, step_d, dir_q, dir_d;
    logic [POS_W-1:0] pos_q, pos_d;

    always_comb begin
        sw_s1_d  = sw;
        sw_s2_d  = sw_s1_q;
        dt_s1_d  = dt;
        dt_s2_d  = dt_s1_q;
        cnt_a_d  = cnt_a_q;
        cnt_b_d  = cnt_b_q;
        a_db_d   = a_db_q;
        b_db_d   = b_db_q;
        a_prev_d = a_db_q;
        b_prev_d = b_db_q;
        step_d   = 1'b0;
        dir_d    = dir_q;
        pos_d    = pos_q;

        // Debounce: accept a change only after DEB_CYCLES consecutive differing samples
        if (sw_s2_q == a_db_q) begin
            cnt_a_d = '0;
        end else if (cnt_a_q == DEB_MAX) begin
            a_db_d  = sw_s2_q;
            cnt_a_d = '0;
        end else begin
            cnt_a_d = cnt_a_q + CNT_W'(1);
        end

        if (dt_s2_q == b_db_q) begin
            cnt_b_d = '0;
        end else if (cnt_b_q == DEB_MAX) begin
            b_db_d  = dt_s2_q;
            cnt_b_d = '0;
        end else begin
            cnt_b_d = cnt_b_q + CNT_W'(1);
        end

        // b_prev_q is B as it was before the cycle A rose, so a simultaneous B change is ignored
        if (!a_prev_q && a_db_q) begin
            step_d = 1'b1;
            dir_d  = b_prev_q;
            if (b_prev_q) begin
                pos_d = (pos_q == POS_MAX) ? '0 : pos_q + POS_W'(1);
            end else begin
                pos_d = (pos_q == '0) ? POS_MAX : pos_q - POS_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1_q  <= 1'b0;
            sw_s2_q  <= 1'b0;
            dt_s1_q  <= 1'b0;
            dt_s2_q  <= 1'b0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            a_db_q   <= 1'b0;
            b_db_q   <= 1'b0;
            a_prev_q <= 1'b0;
            b_prev_q <= 1'b0;
            step_q   <= 1'b0;
            dir_q    <= 1'b1;
            pos_q    <= '0;
        end else begin
            sw_s1_q  <= sw_s1_d;
            sw_s2_q  <= sw_s2_d;
            dt_s1_q  <= dt_s1_d;
            dt_s2_q  <= dt_s2_d;
            cnt_a_q  <= cnt_a_d;
            cnt_b_q  <= cnt_b_d;
            a_db_q   <= a_db_d;
            b_db_q   <= b_db_d;
            a_prev_q <= a_prev_d;
            b_prev_q <= b_prev_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            pos_q    <= pos_d;
        end
    end

    assign step = step_q;
    assign dir  = dir_q;
    assign pos  = pos_q;
    assign a_db = a_db_q;
    assign b_db = b_db_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed scenarios plus random encoder activity,
// every cycle compared against a sample-window reference model.
module tb_quad_step_decoder;

    localparam int unsigned DEB = 4;
    localparam int unsigned PMOD = 20;

    logic       clk, rst, sw, dt;
    logic       step, dir, a_db, b_db;
    logic [4:0] pos;

    int n_vec = 0;
    int n_err = 0;
    int n_steps = 0;

    // Reference model state
    logic m_a, m_b, m_a_old, m_b_old, m_step, m_dir;
    int   m_pos;
    logic pq_a[$], pq_b[$], wq_a[$], wq_b[$];

    quad_step_decoder #(.DEB_CYCLES(DEB), .POS_MOD(PMOD)) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw),
        .dt  (dt),
        .step(step),
        .dir (dir),
        .pos (pos),
        .a_db(a_db),
        .b_db(b_db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic all_differ(input logic q[$], input logic v);
        foreach (q[i]) if (q[i] == v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        pq_a = '{1'b0, 1'b0};
        pq_b = '{1'b0, 1'b0};
        wq_a.delete();
        wq_b.delete();
        for (int i = 0; i < int'(DEB); i++) begin
            wq_a.push_back(1'b0);
            wq_b.push_back(1'b0);
        end
        m_a = 0; m_b = 0; m_a_old = 0; m_b_old = 0;
        m_step = 0; m_dir = 1; m_pos = 0;
    endtask

    // A debounced value flips once the last DEB synchronized samples all disagree with it
    task automatic model_step(input logic s, input logic d);
        logic sa, sb, rise;
        rise   = !m_a_old && m_a;
        m_step = rise;
        if (rise) begin
            m_dir = m_b_old;
            m_pos = m_b_old ? (m_pos + 1) % PMOD : (m_pos + PMOD - 1) % PMOD;
        end
        m_a_old = m_a;
        m_b_old = m_b;
        sa = pq_a.pop_front(); pq_a.push_back(s);
        sb = pq_b.pop_front(); pq_b.push_back(d);
        void'(wq_a.pop_front()); wq_a.push_back(sa);
        void'(wq_b.pop_front()); wq_b.push_back(sb);
        if (all_differ(wq_a, m_a)) m_a = !m_a;
        if (all_differ(wq_b, m_b)) m_b = !m_b;
    endtask

    task automatic tick(input logic s, input logic d, input logic r);
        @(negedge clk);
        sw = s; dt = d; rst = r;
        @(posedge clk);
        if (r) model_reset();
        else   model_step(s, d);
        #1;
        chk("step", 32'(step), 32'(m_step));
        chk("dir",  32'(dir),  32'(m_dir));
        chk("pos",  32'(pos),  32'(m_pos));
        chk("a_db", 32'(a_db), 32'(m_a));
        chk("b_db", 32'(b_db), 32'(m_b));
        if (step) n_steps++;
    endtask

    task automatic hold(input logic s, input logic d, input logic r, input int n);
        for (int i = 0; i < n; i++) tick(s, d, r);
    endtask

    initial begin
        int first, s0, lat;
        logic v, rs, rd, rr;
        sw = 0; dt = 0; rst = 1;
        model_reset();

        // Reset state
        hold(0, 0, 1, 3);
        chk("rst_dir", 32'(dir), 1);
        chk("rst_pos", 32'(pos), 0);
        chk("rst_step", 32'(step), 0);

        // Clean up step: latency and pos 0->1
        hold(0, 1, 0, 8);
        first = -1; lat = -1;
        for (int i = 1; i <= 12; i++) begin
            tick(1, 1, 0);
            if (a_db && lat < 0) lat = i;
            if (step && first < 0) first = i;
        end
        chk("s034_adb_lat", 32'(lat), 6);
        chk("s034_step_lat", 32'(first), 7);
        chk("s034_pos", 32'(pos), 1);
        chk("s034_dir", 32'(dir), 1);
        hold(0, 1, 0, 10);

        // Down step from 0 wraps to 19
        hold(0, 0, 1, 2);
        hold(0, 0, 0, 2);
        hold(1, 0, 0, 10);
        chk("s035_pos", 32'(pos), 19);
        chk("s035_dir", 32'(dir), 0);

        // Bouncing A produces a single step only once stable
        hold(0, 1, 1, 2);
        hold(0, 1, 0, 8);
        s0 = n_steps;
        for (int i = 0; i < 30; i++) begin
            v = 1'((i / 2) % 2);
            tick(v, 1, 0);
        end
        chk("s036_bounce_steps", 32'(n_steps - s0), 0);
        hold(1, 1, 0, 12);
        chk("s036_steps", 32'(n_steps - s0), 1);

        // Twenty up steps wrap back to 0
        hold(0, 1, 1, 2);
        hold(0, 1, 0, 8);
        s0 = n_steps;
        for (int i = 0; i < 20; i++) begin
            hold(1, 1, 0, 8);
            hold(0, 1, 0, 8);
        end
        chk("s037_steps", 32'(n_steps - s0), 20);
        chk("s037_pos", 32'(pos), 0);

        // A and B rise together: direction uses B before the update
        hold(0, 0, 0, 8);
        hold(1, 1, 0, 10);
        chk("simul_dir", 32'(dir), 0);
        chk("simul_pos", 32'(pos), 19);
        hold(0, 1, 0, 8);

        // B activity alone never steps
        s0 = n_steps;
        for (int i = 0; i < 25; i++) begin
            rd = 1'($urandom);
            hold(0, rd, 0, $urandom_range(1, 8));
        end
        chk("s038_steps", 32'(n_steps - s0), 0);
        chk("s038_pos", 32'(pos), 19);

        // Reset mid-debounce aborts the step
        hold(0, 1, 1, 2);
        hold(0, 1, 0, 8);
        s0 = n_steps;
        hold(1, 1, 0, 3);
        hold(0, 1, 1, 3);
        chk("s039_adb", 32'(a_db), 0);
        chk("s039_dir", 32'(dir), 1);
        hold(0, 1, 0, 12);
        chk("s039_steps", 32'(n_steps - s0), 0);
        chk("s039_pos", 32'(pos), 0);

        // Reset release with A held high yields one step
        hold(1, 0, 1, 2);
        s0 = n_steps;
        hold(1, 0, 0, 12);
        chk("rel_steps", 32'(n_steps - s0), 1);
        chk("rel_pos", 32'(pos), 19);

        // Random encoder activity with bursts of bounce and occasional reset
        for (int k = 0; k < 500; k++) begin
            rr = ($urandom_range(0, 59) == 0);
            rs = 1'($urandom);
            rd = 1'($urandom);
            hold(rs, rd, rr, $urandom_range(1, 12));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
